// File: rtl/bus_target_pkg.sv
// Shared definitions for bus targets: FSM states, bus widths and a
// constant-foldable log2 helper.
package bus_target_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned BE_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERROR,
        ST_READ_WAIT,
        ST_READ_BURST,
        ST_READ_END,
        ST_WRITE_WAIT,
        ST_WRITE_BURST
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_target_ram.sv
// Single-port word RAM with registered read and per-byte write enables.
module bus_target_ram
    import bus_target_pkg::*;
#(
    parameter int unsigned nrOfWords = 1024,
    parameter int unsigned addr_w    = 10
) (
    input  logic                clock,
    input  logic [addr_w-1:0]   address,
    input  logic [BE_W-1:0]     write_enables,
    input  logic [DATA_W-1:0]   write_data,
    output logic [DATA_W-1:0]   read_data
);

    logic [DATA_W-1:0] mem [nrOfWords];

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (write_enables[i]) begin
                mem[address][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
        read_data <= mem[address];
    end

endmodule

// File: rtl/bus_ssram_target.sv
// SSRAM bus target: decodes its address window, runs single/burst reads and
// writes against bus_target_ram, and drives zero on every idle output.
module bus_ssram_target
    import bus_target_pkg::*;
#(
    parameter logic [31:0] baseAddress = 32'h5000_0000,
    parameter int unsigned nrOfWords   = 1024,
    parameter int unsigned waitStates  = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 begin_transaction_in,
    input  logic [DATA_W-1:0]    address_data_in,
    input  logic [BE_W-1:0]      byte_enables_in,
    input  logic [BURST_W-1:0]   burst_size_in,
    input  logic                 read_n_write_in,
    input  logic                 data_valid_in,
    input  logic                 end_transaction_in,
    output logic [DATA_W-1:0]    address_data_out,
    output logic                 data_valid_out,
    output logic                 end_transaction_out,
    output logic                 busy_out,
    output logic                 error_out
);

    localparam int unsigned AW      = clog2(nrOfWords);
    localparam logic [3:0]  WS      = 4'(waitStates);
    localparam logic [3:0]  WS_LAST = WS - 4'd1;

    state_t          state, state_nxt;
    logic [AW-1:0]   word_addr, word_addr_nxt;
    logic [8:0]      beat_cnt, beat_cnt_nxt;
    logic [8:0]      beat_total, beat_total_nxt;
    logic [3:0]      wait_cnt, wait_cnt_nxt;
    logic [BE_W-1:0] be_q, be_nxt;

    logic [BE_W-1:0]   ram_we;
    logic [DATA_W-1:0] ram_rdata;

    logic selected;
    logic bad_request;

    assign selected    = (address_data_in[31:AW+2] == baseAddress[31:AW+2]);
    assign bad_request = (address_data_in[1:0] != 2'b00) ||
                         ((burst_size_in != '0) && (byte_enables_in != '1));

    bus_target_ram #(
        .nrOfWords (nrOfWords),
        .addr_w    (AW)
    ) u_ram (
        .clock         (clock),
        .address       (word_addr),
        .write_enables (ram_we),
        .write_data    (address_data_in),
        .read_data     (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            word_addr  <= '0;
            beat_cnt   <= '0;
            beat_total <= '0;
            wait_cnt   <= '0;
            be_q       <= '0;
        end else begin
            state      <= state_nxt;
            word_addr  <= word_addr_nxt;
            beat_cnt   <= beat_cnt_nxt;
            beat_total <= beat_total_nxt;
            wait_cnt   <= wait_cnt_nxt;
            be_q       <= be_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        word_addr_nxt       = word_addr;
        beat_cnt_nxt        = beat_cnt;
        beat_total_nxt      = beat_total;
        wait_cnt_nxt        = wait_cnt;
        be_nxt              = be_q;
        ram_we              = '0;
        address_data_out    = '0;
        data_valid_out      = 1'b0;
        end_transaction_out = 1'b0;
        busy_out            = 1'b0;
        error_out           = 1'b0;

        case (state)
            ST_IDLE: begin
                if (begin_transaction_in && selected) begin
                    word_addr_nxt  = address_data_in[AW+1:2];
                    beat_cnt_nxt   = '0;
                    beat_total_nxt = {1'b0, burst_size_in} + 9'd1;
                    wait_cnt_nxt   = '0;
                    be_nxt         = byte_enables_in;
                    if (bad_request) begin
                        state_nxt = ST_ERROR;
                    end else if (read_n_write_in) begin
                        state_nxt = ST_READ_WAIT;
                    end else if (WS == 4'd0) begin
                        state_nxt = ST_WRITE_BURST;
                    end else begin
                        state_nxt = ST_WRITE_WAIT;
                    end
                end
            end

            ST_ERROR: begin
                error_out = 1'b1;
                state_nxt = ST_IDLE;
            end

            // The last wait cycle presents the first word to the RAM, so the
            // data is ready for the first beat.
            ST_READ_WAIT: begin
                if (end_transaction_in) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == WS) begin
                    state_nxt     = ST_READ_BURST;
                    word_addr_nxt = word_addr + AW'(1);
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end

            ST_READ_BURST: begin
                data_valid_out   = 1'b1;
                address_data_out = ram_rdata;
                word_addr_nxt    = word_addr + AW'(1);
                beat_cnt_nxt     = beat_cnt + 9'd1;
                if (end_transaction_in) begin
                    state_nxt = ST_IDLE;
                end else if (beat_cnt + 9'd1 == beat_total) begin
                    state_nxt = ST_READ_END;
                end
            end

            ST_READ_END: begin
                end_transaction_out = 1'b1;
                state_nxt           = ST_IDLE;
            end

            ST_WRITE_WAIT: begin
                busy_out = 1'b1;
                if (end_transaction_in) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == WS_LAST) begin
                    state_nxt = ST_WRITE_BURST;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end

            ST_WRITE_BURST: begin
                if (data_valid_in && (beat_cnt != beat_total)) begin
                    ram_we        = be_q;
                    word_addr_nxt = word_addr + AW'(1);
                    beat_cnt_nxt  = beat_cnt + 9'd1;
                end
                if (end_transaction_in) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_ssram_target.sv
// Randomized bench for bus_ssram_target: two instances (1024 words/0 waits and
// 16 words/3 waits) checked cycle by cycle against a word-array memory model.
module tb_bus_ssram_target;

    localparam logic [31:0] BASE = 32'h5000_0000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        begin_in [2];
    logic [31:0] adi      [2];
    logic [3:0]  be_in    [2];
    logic [7:0]  bs_in    [2];
    logic        rnw      [2];
    logic        dvi      [2];
    logic        eti      [2];
    logic [31:0] ado      [2];
    logic        dvo      [2];
    logic        eto      [2];
    logic        busy     [2];
    logic        err      [2];

    bus_ssram_target #(.baseAddress(BASE), .nrOfWords(1024), .waitStates(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .begin_transaction_in(begin_in[0]), .address_data_in(adi[0]),
        .byte_enables_in(be_in[0]), .burst_size_in(bs_in[0]),
        .read_n_write_in(rnw[0]), .data_valid_in(dvi[0]),
        .end_transaction_in(eti[0]), .address_data_out(ado[0]),
        .data_valid_out(dvo[0]), .end_transaction_out(eto[0]),
        .busy_out(busy[0]), .error_out(err[0])
    );

    bus_ssram_target #(.baseAddress(BASE), .nrOfWords(16), .waitStates(3)) u_dut1 (
        .clock(clock), .reset(reset),
        .begin_transaction_in(begin_in[1]), .address_data_in(adi[1]),
        .byte_enables_in(be_in[1]), .burst_size_in(bs_in[1]),
        .read_n_write_in(rnw[1]), .data_valid_in(dvi[1]),
        .end_transaction_in(eti[1]), .address_data_out(ado[1]),
        .data_valid_out(dvo[1]), .end_transaction_out(eto[1]),
        .busy_out(busy[1]), .error_out(err[1])
    );

    logic [31:0] mem_m [2][1024];
    int n_cmp = 0;
    int n_err = 0;

    function automatic int depth(input int sel);
        return (sel == 1) ? 16 : 1024;
    endfunction

    function automatic int ws_of(input int sel);
        return (sel == 1) ? 3 : 0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input int sel, input string tag);
        check_eq({tag, "_data"}, ado[sel], 32'h0);
        check_eq({tag, "_ctl"}, 32'({dvo[sel], eto[sel], busy[sel], err[sel]}), 32'h0);
    endtask

    task automatic start(input int sel, input logic [31:0] addr, input logic [3:0] be,
                         input int burst, input logic rd);
        begin_in[sel] = 1'b1;
        adi[sel]      = addr;
        be_in[sel]    = be;
        bs_in[sel]    = 8'(burst);
        rnw[sel]      = rd;
        @(posedge clock); #1;
        begin_in[sel] = 1'b0;
    endtask

    // mode 1 sends start, start+1, ...; mode 0 sends random words
    task automatic do_write(input int sel, input logic [31:0] addr, input logic [3:0] be,
                            input int burst, input int nsend, input int mode,
                            input logic [31:0] first);
        int n, ws, w, acc, cyc, idx;
        logic [31:0] d;
        n   = depth(sel);
        ws  = ws_of(sel);
        w   = int'(addr[13:2]) % n;
        start(sel, addr, be, burst, 1'b0);
        acc = 0;
        cyc = 1;
        d   = (mode == 1) ? first : $urandom;
        while (acc < nsend) begin
            dvi[sel] = 1'b1;
            adi[sel] = d;
            @(negedge clock);
            check_eq("wr_busy", 32'(busy[sel]), 32'(cyc <= ws));
            check_eq("wr_quiet", 32'({dvo[sel], eto[sel], err[sel]}), 32'h0);
            @(posedge clock); #1;
            if (cyc > ws) begin
                if (acc <= burst) begin
                    idx = (w + acc) % n;
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mem_m[sel][idx][8*b +: 8] = d[8*b +: 8];
                end
                acc++;
                d = (mode == 1) ? d + 32'd1 : $urandom;
            end
            cyc++;
        end
        dvi[sel] = 1'b0;
        eti[sel] = 1'b1;
        @(posedge clock); #1;
        eti[sel] = 1'b0;
    endtask

    // cut_at > 0 ends the read in that cycle, by end_transaction_in or by reset
    task automatic do_read(input int sel, input logic [31:0] addr, input int burst,
                           input int cut_at, input bit use_reset);
        int n, f, w, last, stop;
        bit live, exp_dv, exp_et;
        logic [31:0] exp_d;
        n    = depth(sel);
        f    = 2 + ws_of(sel);
        w    = int'(addr[13:2]) % n;
        last = f + burst + 1;
        stop = (cut_at > 0) ? cut_at + 1 : last + 1;
        start(sel, addr, 4'hF, burst, 1'b1);
        for (int c = 1; c <= stop; c++) begin
            if (c == cut_at) begin
                if (use_reset) reset = 1'b1;
                else eti[sel] = 1'b1;
            end
            @(negedge clock);
            live   = (cut_at == 0) || (c <= cut_at);
            exp_dv = live && (c >= f) && (c <= f + burst);
            exp_d  = exp_dv ? mem_m[sel][(w + c - f) % n] : 32'h0;
            exp_et = (cut_at == 0) && (c == last);
            check_eq("rd_valid", 32'(dvo[sel]), 32'(exp_dv));
            check_eq("rd_data", ado[sel], exp_d);
            check_eq("rd_end", 32'(eto[sel]), 32'(exp_et));
            check_eq("rd_misc", 32'({busy[sel], err[sel]}), 32'h0);
            @(posedge clock); #1;
            eti[sel] = 1'b0;
            reset    = 1'b0;
        end
    endtask

    task automatic do_error(input int sel, input logic [31:0] addr, input logic [3:0] be,
                            input int burst, input logic rd);
        start(sel, addr, be, burst, rd);
        @(negedge clock);
        check_eq("err_pulse", 32'(err[sel]), 32'h1);
        check_eq("err_others", 32'({dvo[sel], eto[sel], busy[sel]}), 32'h0);
        check_eq("err_data", ado[sel], 32'h0);
        @(posedge clock); #1;
        @(negedge clock);
        check_quiet(sel, "err_after");
        @(posedge clock); #1;
    endtask

    task automatic do_unsel(input int sel, input logic [31:0] addr, input logic rd);
        start(sel, addr, 4'hF, 0, rd);
        for (int c = 0; c < 3; c++) begin
            dvi[sel] = ~rd;
            adi[sel] = $urandom;
            @(negedge clock);
            check_quiet(sel, "unsel");
            @(posedge clock); #1;
        end
        dvi[sel] = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sel, kind, n, burst;
        logic [31:0] a;
        for (int s = 0; s < 2; s++) begin
            begin_in[s] = 1'b0; adi[s] = '0; be_in[s] = '0; bs_in[s] = '0;
            rnw[s] = 1'b0; dvi[s] = 1'b0; eti[s] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check_quiet(0, "reset0");
        check_quiet(1, "reset1");
        @(posedge clock); #1;
        reset = 1'b0;

        for (int k = 0; k < 4; k++)
            do_write(0, BASE + 32'(k * 1024), 4'hF, 255, 256, 0, 32'h0);
        do_write(1, BASE, 4'hF, 15, 16, 0, 32'h0);

        do_write(0, BASE + 32'h10, 4'hF, 0, 1, 1, 32'hDEADBEEF);
        do_read(0, BASE + 32'h10, 0, 0, 1'b0);
        do_write(0, BASE + 32'h20, 4'hF, 7, 8, 1, 32'h0);
        do_read(0, BASE + 32'h20, 7, 0, 1'b0);
        do_write(1, BASE + 32'h8, 4'hF, 5, 6, 1, 32'h100);
        do_read(1, BASE + 32'h8, 5, 0, 1'b0);
        do_write(0, BASE + 32'h60, 4'hF, 2, 6, 1, 32'h700);
        do_read(0, BASE + 32'h60, 3, 0, 1'b0);

        do_error(0, BASE + 32'h2, 4'hF, 0, 1'b1);
        do_error(0, BASE + 32'h40, 4'b0011, 3, 1'b0);
        do_error(1, BASE + 32'h5, 4'hF, 0, 1'b0);
        do_read(0, BASE + 32'h40, 3, 0, 1'b0);

        do_read(0, BASE + 32'(1023 * 4), 3, 0, 1'b0);
        do_read(1, BASE + 32'(15 * 4), 3, 0, 1'b0);
        do_write(0, BASE + 32'h80, 4'hF, 0, 1, 1, 32'h11223344);
        do_write(0, BASE + 32'h80, 4'b0001, 0, 1, 1, 32'h000000AA);
        do_read(0, BASE + 32'h80, 0, 0, 1'b0);

        do_read(0, BASE + 32'h100, 9, 4, 1'b0);
        do_read(1, BASE + 32'h0, 9, 7, 1'b0);
        do_read(0, BASE + 32'h100, 9, 1, 1'b0);
        do_unsel(0, 32'h6000_0010, 1'b1);
        do_unsel(0, 32'h6000_0010, 1'b0);
        do_unsel(1, BASE + 32'h40, 1'b1);
        do_unsel(1, BASE + 32'h44, 1'b0);
        do_read(0, BASE + 32'h200, 19, 5, 1'b1);
        do_read(0, BASE + 32'h200, 19, 0, 1'b0);

        repeat (80) begin
            sel   = int'($urandom_range(0, 1));
            n     = depth(sel);
            kind  = int'($urandom_range(0, 9));
            burst = int'($urandom_range(0, 15));
            a     = BASE + 32'($urandom_range(0, n - 1) * 4);
            if (kind <= 3) begin
                if (burst == 0)
                    do_write(sel, a, 4'($urandom_range(1, 15)), 0, int'($urandom_range(1, 2)), 0, 32'h0);
                else
                    do_write(sel, a, 4'hF, burst, int'($urandom_range(1, burst + 3)), 0, 32'h0);
            end else if (kind <= 7) begin
                do_read(sel, a, burst, 0, 1'b0);
            end else if (kind == 8) begin
                if (burst[0])
                    do_error(sel, a | 32'($urandom_range(1, 3)), 4'hF, burst, burst[1]);
                else
                    do_error(sel, a, 4'($urandom_range(0, 14)), burst + 1, burst[1]);
            end else begin
                do_read(sel, a, burst, int'($urandom_range(1, 2 + ws_of(sel) + burst)), 1'b0);
            end
        end

        for (int k = 0; k < 4; k++)
            do_read(0, BASE + 32'(k * 1024), 255, 0, 1'b0);
        do_read(1, BASE, 15, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_ssram_target.md
# bus_ssram_target

Memory-mapped SSRAM that responds as a target on the shared system bus. Receives single-word and burst transactions from bus initiators (the CI-controlled DMA engine, the CPU) and returns read data or stores write data. Sits on the bus next to the SDRAM controller. Gives the DMA engine a fast, deterministic second memory for block transfers and verification.

## Interface
- baseAddress, 32'h50000000: byte base address; must be aligned to the memory size.
- nrOfWords, 1024: depth in 32-bit words; power of two, 16..4096.
- waitStates, 0: extra latency cycles (0..15) before the first read beat and write-accept stall cycles.
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- begin_transaction_in  input  1  initiator starts a transaction; address, burst size, direction and enables are valid this cycle.
- address_data_in  input  32  byte address on begin; write data on data_valid_in.
- byte_enables_in  input  4  byte lanes, sampled on begin.
- burst_size_in  input  8  beats minus one, sampled on begin.
- read_n_write_in  input  1  1 = read, sampled on begin.
- data_valid_in  input  1  write beat present.
- end_transaction_in  input  1  initiator ends a write, or aborts.
- address_data_out  output  32  read data; 0 when not driving.
- data_valid_out  output  1  read beat present.
- end_transaction_out  output  1  one-cycle pulse after the last read beat.
- busy_out  output  1  write stall.
- error_out  output  1  one-cycle error pulse.

## Operation
- Selection: address_data_in[31:log2(nrOfWords)+2] equals the same field of baseAddress. If not selected, the transaction is ignored entirely: no output changes.
- Error check when selected:
  - address_data_in[1:0] != 0, or
  - burst_size_in != 0 with byte_enables_in != 4'b1111.
  - Action: error_out = 1 for one cycle, no data phase, return to IDLE.
- Word address = address bits [log2(nrOfWords)+1:2]. It increments by 1 per beat, modulo nrOfWords (a burst past the top wraps to word 0).
- Beat counter is 9 bits and terminates at burst_size+1 (1..256 beats).
- FSM states:
  - IDLE: wait for begin_transaction_in.
  - ERROR: pulse error_out, then IDLE.
  - READ_WAIT: waitStates cycles plus 1 cycle of RAM latency.
  - READ_BURST: one beat per clock, no stalls.
  - READ_END: end_transaction_out pulse, then IDLE.
  - WRITE_WAIT: busy_out = 1 for waitStates cycles; skipped if waitStates = 0.
  - WRITE_BURST: every data_valid_in with busy_out = 0 writes address_data_in using the latched byte enables. Leaves to IDLE on end_transaction_in.
- Write beats beyond burst_size+1 are dropped.
- begin_transaction_in outside IDLE is ignored.
- end_transaction_in during READ_WAIT or READ_BURST aborts: IDLE next cycle, no end_transaction_out.
- All outputs are 0 whenever not actively driven (the bus is wired-OR).

## Timing
- Reset: state IDLE; all outputs 0; counters 0. RAM contents are retained. Reset mid-burst aborts: outputs are 0 in the cycle after reset is sampled.
- Read: begin at cycle T → first data_valid_out at T+2+waitStates → beats contiguous → last beat at T+2+waitStates+burst_size → end_transaction_out at the following cycle.
- Write: begin at T → busy_out high during T+1..T+waitStates. A beat presented in a busy_out = 1 cycle is not accepted; the initiator holds it. The RAM write occurs on the clock edge that samples the accepted beat.
- Error: error_out at T+1 only.
- Back-to-back: a new begin_transaction_in is accepted in the cycle the FSM is IDLE, i.e. the cycle after end_transaction_out or after an accepted end_transaction_in.
- Write then read of the same word with no idle gap returns the new data.

## Structure
- Package bus_target_pkg holds:
  - FSM state encoding: 3 bits, 7 states.
  - Bus width constants: data 32, burst 8, byte enables 4.
  - Function clog2 for deriving the word-address width.
- Sub-module bus_target_ram: single-port, synchronous read, per-byte write enable, nrOfWords x 32. The target instantiates it once; address and write-enable muxing stay in bus_ssram_target.

## Test plan
- Single write 0xDEADBEEF to baseAddress+0x10 with enables 4'b1111, then single read of the same address (waitStates = 0) → data_valid_out at T+2 with 0xDEADBEEF; end_transaction_out at T+3.
- Burst write of 8 beats (burst_size 7) with values 0..7 at baseAddress+0x20, then burst read of the same range → 8 contiguous beats 0..7, then end_transaction_out exactly one cycle after the last beat.
- waitStates = 3, burst write with the initiator asserting data_valid_in from T+1 → busy_out high at T+1..T+3; the first word stored is the beat held through T+4; read latency becomes T+5.
- Misaligned address baseAddress+0x2, and separately burst_size 3 with enables 4'b0011 → error_out single pulse at T+1; memory unchanged; data_valid_out stays 0.
- Wrap and partial write: a 4-beat read starting at the last word returns words nrOfWords-1, 0, 1, 2. A single write 0x000000AA with enables 4'b0001 over 0x11223344 reads back 0x112233AA.
- Abort and unselected:
  - end_transaction_in mid-read → no further beats and no end_transaction_out.
  - Address outside the window → all outputs remain 0.
  - reset during a burst → outputs 0 next cycle; earlier-written data still readable.
